// File: rtl/wm8731_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wm8731_cfg_seq: WM8731 register-table sequencer with NACK retry and      |
// | automatic re-send of runtime-updated entries.        Revision: 1.0       |
// +--------------------------------------------------------------------------+
module wm8731_cfg_seq #(
  parameter int                    NUM_REGS   = 10,
  parameter int                    IDX_W      = 4,
  parameter logic [16*NUM_REGS-1:0] INIT_TABLE = {16'h1201, 16'h1018, 16'h0E02, 16'h0C00, 16'h0A08,
                                                  16'h087A, 16'h0671, 16'h0471, 16'h0217, 16'h0017},
  parameter int                    MAX_RETRY  = 3,
  parameter int                    GAP_CYC    = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic             iWR_EN,
  input  logic [IDX_W-1:0] iWR_IDX,
  input  logic [8:0]       iWR_DATA,
  output logic             oI2C_REQ,
  output logic [15:0]      oI2C_DATA,
  input  logic             iI2C_ACK,
  input  logic             iI2C_NACK,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR,
  output logic [IDX_W-1:0] oERR_IDX
);

  localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int c_GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [c_GAP_W-1:0]   c_GAP_LAST  = (GAP_CYC > 1) ? c_GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]     c_LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W:0]       c_NUM_REGS  = (IDX_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_REQ  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                r_state, w_state_nx;
  logic                  r_flush, w_flush_nx;
  logic [IDX_W-1:0]      r_idx, w_idx_nx;
  logic [c_RETRY_W-1:0]  r_retry, w_retry_nx;
  logic [c_GAP_W-1:0]    r_gap, w_gap_nx;
  logic                  r_req, w_req_nx;
  logic [15:0]           r_data, w_data_nx;
  logic                  r_busy, r_done, w_done_nx;
  logic                  r_err, w_err_nx;
  logic [IDX_W-1:0]      r_err_idx, w_err_idx_nx;
  logic                  w_clr_all, w_clr_one;

  logic [15:0]           r_table [NUM_REGS];
  logic [NUM_REGS-1:0]   r_dirty, w_dirty_nx;
  logic [IDX_W-1:0]      w_low_idx;
  logic                  w_wr_ok, w_gap_done;

  assign w_wr_ok    = iWR_EN && ({1'b0, iWR_IDX} < c_NUM_REGS);
  assign w_gap_done = (GAP_CYC <= 1) || (r_gap == c_GAP_LAST);

  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (r_dirty[i]) w_low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_flush_nx   = r_flush;
    w_idx_nx     = r_idx;
    w_retry_nx   = r_retry;
    w_gap_nx     = r_gap;
    w_req_nx     = r_req;
    w_data_nx    = r_data;
    w_done_nx    = 1'b0;
    w_err_nx     = r_err;
    w_err_idx_nx = r_err_idx;
    w_clr_all    = 1'b0;
    w_clr_one    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iSTART) begin
          w_flush_nx = 1'b0;
          w_idx_nx   = '0;
          w_retry_nx = '0;
          w_err_nx   = 1'b0;
          w_clr_all  = 1'b1;
          w_state_nx = S_LOAD;
        end else if (|r_dirty) begin
          w_flush_nx = 1'b1;
          w_idx_nx   = w_low_idx;
          w_retry_nx = '0;
          w_state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        w_data_nx  = r_table[r_idx];
        w_req_nx   = 1'b1;
        w_state_nx = S_REQ;
      end
      S_REQ: begin
        // A simultaneous ACK and NACK is taken as a NACK.
        if (iI2C_NACK) begin
          w_req_nx = 1'b0;
          if (r_retry < c_MAX_RETRY) begin
            w_retry_nx = r_retry + 1'b1;
            w_gap_nx   = '0;
            w_state_nx = S_GAP;
          end else begin
            w_err_nx     = 1'b1;
            w_err_idx_nx = r_idx;
            w_clr_one    = 1'b1;
            w_retry_nx   = '0;
            w_state_nx   = S_IDLE;
          end
        end else if (iI2C_ACK) begin
          w_req_nx   = 1'b0;
          w_clr_one  = 1'b1;
          w_retry_nx = '0;
          w_gap_nx   = '0;
          if (!r_flush && r_idx == c_LAST_IDX) begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            if (!r_flush) w_idx_nx = r_idx + 1'b1;
            w_state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Non-zero retry means the word in flight was NACKed and must be re-sent.
        if (w_gap_done) begin
          w_state_nx = (!r_flush || r_retry != '0) ? S_LOAD : S_IDLE;
        end else begin
          w_gap_nx = r_gap + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_flush   <= 1'b0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_flush   <= w_flush_nx;
      r_idx     <= w_idx_nx;
      r_retry   <= w_retry_nx;
      r_gap     <= w_gap_nx;
      r_req     <= w_req_nx;
      r_data    <= w_data_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_err_idx <= w_err_idx_nx;
    end
  end

  // A runtime write wins over an ACK-clear of the same entry, so it is re-sent.
  always_comb begin
    w_dirty_nx = r_dirty;
    if (w_clr_all) w_dirty_nx = '0;
    if (w_clr_one) w_dirty_nx[r_idx] = 1'b0;
    if (w_wr_ok)   w_dirty_nx[iWR_IDX] = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_REGS; i++) r_table[i] <= INIT_TABLE[16*i +: 16];
      r_dirty <= '0;
    end else begin
      if (w_wr_ok) r_table[iWR_IDX][8:0] <= iWR_DATA;
      r_dirty <= w_dirty_nx;
    end
  end

  assign oI2C_REQ  = r_req;
  assign oI2C_DATA = r_data;
  assign oBUSY     = r_busy;
  assign oDONE     = r_done;
  assign oERR      = r_err;
  assign oERR_IDX  = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_wm8731_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wm8731_cfg_seq: directed/randomised bench with a table-level model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wm8731_cfg_seq;

  localparam int GAP_CYC = 16;
  localparam int NREG    = 10;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iSTART = 1'b0;
  logic        iWR_EN = 1'b0;
  logic [3:0]  iWR_IDX = '0;
  logic [8:0]  iWR_DATA = '0;
  logic        iI2C_ACK = 1'b0;
  logic        iI2C_NACK = 1'b0;
  logic        oI2C_REQ, oBUSY, oDONE, oERR;
  logic [15:0] oI2C_DATA;
  logic [3:0]  oERR_IDX;

  wm8731_cfg_seq dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART),
    .iWR_EN(iWR_EN), .iWR_IDX(iWR_IDX), .iWR_DATA(iWR_DATA),
    .oI2C_REQ(oI2C_REQ), .oI2C_DATA(oI2C_DATA),
    .iI2C_ACK(iI2C_ACK), .iI2C_NACK(iI2C_NACK),
    .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR), .oERR_IDX(oERR_IDX)
  );

  always #5 iCLK = ~iCLK;

  localparam logic [15:0] INIT_V [NREG] = '{16'h0017, 16'h0217, 16'h0471, 16'h0671, 16'h087A,
                                            16'h0A08, 16'h0C00, 16'h0E02, 16'h1018, 16'h1201};

  logic [15:0] m_table [NREG];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge iCLK) if (oDONE === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_table[i] = INIT_V[i];
  endtask

  task automatic m_write(input int idx, input logic [8:0] d);
    if (idx < NREG) m_table[idx][8:0] = d;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req"},  oI2C_REQ, 0);
    chk({tag, " data"}, oI2C_DATA, 0);
    chk({tag, " busy"}, oBUSY, 0);
    chk({tag, " done"}, oDONE, 0);
    chk({tag, " err"},  {oERR, oERR_IDX}, 0);
  endtask

  task automatic start_seq(input string tag);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    chk({tag, " busy1"}, {oBUSY, oI2C_REQ}, 2'b10);
    tick();
    chk({tag, " req@2"}, oI2C_REQ, 1);
  endtask

  task automatic wr(input int idx, input logic [8:0] d);
    iWR_EN = 1'b1; iWR_IDX = 4'(idx); iWR_DATA = d;
    m_write(idx, d);
    tick();
    iWR_EN = 1'b0;
  endtask

  // resp: 0 ACK, 1 NACK, 2 ACK+NACK together, 3 leave request pending
  task automatic serve(input string tag, input logic [15:0] exp, input int resp,
                       input bit chk_gap, input bit do_wr, input int wi, input logic [8:0] wd);
    int cnt = 0;
    int dly;
    while (oI2C_REQ !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({tag, " req"}, oI2C_REQ, 1);
    chk({tag, " data"}, oI2C_DATA, exp);
    if (chk_gap) chk({tag, " gap"}, (cnt >= GAP_CYC), 1);
    if (resp != 3) begin
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      chk({tag, " hold"}, {oI2C_REQ, oI2C_DATA}, {1'b1, exp});
      iI2C_ACK  = (resp != 1);
      iI2C_NACK = (resp != 0);
      if (do_wr) begin
        iWR_EN = 1'b1; iWR_IDX = 4'(wi); iWR_DATA = wd;
        m_write(wi, wd);
      end
      tick();
      iI2C_ACK = 1'b0; iI2C_NACK = 1'b0; iWR_EN = 1'b0;
      chk({tag, " drop"}, oI2C_REQ, 0);
    end
  endtask

  task automatic serve_range(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++)
      serve($sformatf("%s e%0d", tag, i), m_table[i], 0, (i != 0), 1'b0, 0, '0);
  endtask

  task automatic idle_check(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      tick();
      if (oI2C_REQ) seen = 1'b1;
    end
    chk({tag, " no req"}, seen, 0);
    chk({tag, " idle"}, oBUSY, 0);
  endtask

  initial begin
    int d0, ri;
    logic [8:0] rd;
    m_reset();
    #2;
    chk_reset_outs("rst0");
    tick(); tick();
    iRST_N = 1'b1;
    tick();
    chk_reset_outs("rst1");

    // Full init, all ACKed
    d0 = done_cnt;
    start_seq("initA");
    serve_range("initA", 0, NREG - 1);
    chk("initA busy end", oBUSY, 0);
    tick(); tick();
    chk("initA done", done_cnt - d0, 1);
    chk("initA err", oERR, 0);

    // Runtime updates
    wr(2, 9'h079);
    serve("upd2", 16'h0479, 0, 1'b0, 1'b0, 0, '0);
    chk("upd2 model", m_table[2], 16'h0479);
    idle_check("upd2", 40);
    ri = $urandom_range(6, 9);
    rd = 9'($urandom_range(0, 511));
    wr(ri, rd);
    serve("updR", m_table[ri], 0, 1'b0, 1'b0, 0, '0);
    idle_check("updR", 40);
    rd = 9'($urandom_range(0, 511));
    wr(7, rd);
    wr(5, 9'($urandom_range(0, 511)));
    wr(3, 9'($urandom_range(0, 511)));
    serve("fl7", m_table[7], 0, 1'b0, 1'b0, 0, '0);
    serve("fl3", m_table[3], 0, 1'b1, 1'b0, 0, '0);
    serve("fl5", m_table[5], 0, 1'b1, 1'b0, 0, '0);
    idle_check("fl", 40);

    // Two NACKs (one with simultaneous ACK) then ACK on entry 4
    d0 = done_cnt;
    start_seq("retry");
    serve_range("retry", 0, 3);
    serve("retry e4a", 16'h087A, 1, 1'b1, 1'b0, 0, '0);
    serve("retry e4b", 16'h087A, 2, 1'b1, 1'b0, 0, '0);
    serve("retry e4c", 16'h087A, 0, 1'b1, 1'b0, 0, '0);
    serve_range("retry", 5, NREG - 1);
    tick(); tick();
    chk("retry done", done_cnt - d0, 1);
    chk("retry err", oERR, 0);

    // Retries exhausted on entry 4; iSTART while busy is ignored
    d0 = done_cnt;
    start_seq("abort");
    serve_range("abort", 0, 0);
    iSTART = 1'b1; tick(); iSTART = 1'b0;
    serve_range("abort", 1, 3);
    for (int k = 0; k < 4; k++)
      serve($sformatf("abort e4n%0d", k), 16'h087A, 1, 1'b1, 1'b0, 0, '0);
    chk("abort err", {oERR, oERR_IDX}, {1'b1, 4'd4});
    chk("abort busy", oBUSY, 0);
    idle_check("abort", 40);
    chk("abort done", done_cnt - d0, 0);

    // Write collides with ACK of entry 1
    d0 = done_cnt;
    start_seq("coll");
    chk("coll err clr", oERR, 0);
    serve_range("coll", 0, 0);
    serve("coll e1", m_table[1], 0, 1'b1, 1'b1, 1, 9'h01F);
    serve_range("coll", 2, NREG - 1);
    tick(); tick();
    chk("coll done", done_cnt - d0, 1);
    serve("coll resend", 16'h021F, 0, 1'b0, 1'b0, 0, '0);
    idle_check("coll", 40);

    // Out-of-range write index
    wr(12, 9'h1AA);
    idle_check("oor", 40);

    // Reset while entry 6 is pending
    start_seq("rstm");
    serve_range("rstm", 0, 5);
    serve("rstm e6", m_table[6], 3, 1'b1, 1'b0, 0, '0);
    #3 iRST_N = 1'b0;
    #1 chk_reset_outs("rstm");
    tick(); tick();
    iRST_N = 1'b1;
    m_reset();
    tick();
    d0 = done_cnt;
    start_seq("post");
    serve_range("post", 0, NREG - 1);
    tick(); tick();
    chk("post done", done_cnt - d0, 1);
    chk("post e2 init", m_table[2], 16'h0471);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
